// File: rtl/fetch_mem_responder.sv
// Responder end of the instruction fetch interface: fixed-latency SRAM reads,
// credit-bounded in-flight requests, in-order response FIFO with flush.
module fetch_mem_responder #(
    parameter int          XLEN           = 64,
    parameter logic [63:0] BASE_ADDR      = 64'h8000_0000,
    parameter int          MEM_WORDS      = 4096,
    parameter int          MEM_LAT        = 2,
    parameter int          NR_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         fetch_addr_valid,
    output logic                         fetch_addr_ready,
    input  logic [XLEN-1:0]              fetch_addr,
    output logic                         fetch_data_valid,
    output logic [31:0]                  fetch_data,
    output logic                         fetch_data_err,
    input  logic                         fetch_data_ready,
    input  logic                         flush_i,
    output logic                         mem_req_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    input  logic [31:0]                  mem_rdata_i
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(NR_OUTSTANDING + 1);
    localparam int PTR_W = $clog2(NR_OUTSTANDING);

    localparam logic [XLEN-1:0]  BASE     = XLEN'(BASE_ADDR);
    localparam logic [XLEN-1:0]  WORDS    = XLEN'(MEM_WORDS);
    localparam logic [CNT_W-1:0] CREDITS  = CNT_W'(NR_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NR_OUTSTANDING - 1);

    logic [XLEN-1:0]           word_off;
    logic                      addr_err;
    logic                      accept;
    logic                      push;
    logic                      pop;
    logic [MEM_LAT:1]          pipe_v;
    logic [MEM_LAT:1]          pipe_e;
    logic [31:0]               fifo_data [NR_OUTSTANDING];
    logic [NR_OUTSTANDING-1:0] fifo_err;
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          fifo_cnt;
    logic [CNT_W-1:0]          inflight;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign word_off = (fetch_addr - BASE) >> 2;
    assign addr_err = (fetch_addr[1:0] != 2'b00) || (fetch_addr < BASE) || (word_off >= WORDS);

    // Held low during reset so no SRAM strobe can leak out while rstn is asserted.
    assign fetch_addr_ready = rstn && !flush_i && (inflight < CREDITS);
    assign accept           = fetch_addr_valid && fetch_addr_ready;
    assign mem_req_o        = accept && !addr_err;
    assign mem_addr_o       = word_off[IDX_W-1:0];

    assign fetch_data_valid = (fifo_cnt != '0) && !flush_i;
    assign pop              = fetch_data_valid && fetch_data_ready;
    assign push             = pipe_v[MEM_LAT];
    assign fetch_data       = fetch_data_valid ? fifo_data[rd_ptr] : 32'h0;
    assign fetch_data_err   = fetch_data_valid && fifo_err[rd_ptr];

    // Faulting requests walk the pipeline too, keeping responses in request order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_v <= '0;
            pipe_e <= '0;
        end else if (flush_i) begin
            pipe_v <= '0;
        end else begin
            pipe_v[1] <= accept;
            pipe_e[1] <= addr_err;
            for (int i = 2; i <= MEM_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            fifo_data[wr_ptr] <= pipe_e[MEM_LAT] ? 32'h0 : mem_rdata_i;
            fifo_err[wr_ptr]  <= pipe_e[MEM_LAT];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            inflight <= '0;
        end else if (flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            inflight <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            inflight <= inflight + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && !flush_i && (fifo_cnt == CREDITS)));

endmodule

// File: doc/fetch_mem_responder.md
Name: fetch_mem_responder

Overview:
- Responder end of the core's instruction fetch interface. Accepts fetch address handshakes from the core fetch stage and drives a fixed-latency instruction SRAM.
- Returns 32-bit instruction words in request order through the fetch data handshake.
- Bounds in-flight requests with a credit counter and buffers returned words in a response FIFO.
- A flush drops every pending response, so a squashed fetch stream never delivers stale words.

Parameters:
- XLEN, C::XLEN (64): fetch address width.
- BASE_ADDR, 64'h8000_0000: byte address of SRAM word 0.
- MEM_WORDS, 4096: SRAM depth in 32-bit words; power of 2.
- MEM_LAT, 2: SRAM read latency in cycles (≥1), from mem_req_o to mem_rdata_i.
- NR_OUTSTANDING, 4: maximum accepted-but-not-returned requests; also the response FIFO depth (≥2).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- fetch_addr_valid  in  1  core presents a fetch address
- fetch_addr_ready  out  1  responder accepts the address this cycle
- fetch_addr  in  XLEN  byte address of the instruction
- fetch_data_valid  out  1  response word available
- fetch_data  out  32  instruction word
- fetch_data_err  out  1  response is an access fault; fetch_data is 32'h0
- fetch_data_ready  in  1  core consumes the response
- flush_i  in  1  drop all pending and in-flight responses
- mem_req_o  out  1  SRAM read strobe
- mem_addr_o  out  $clog2(MEM_WORDS)  SRAM word index
- mem_rdata_i  in  32  SRAM read data, valid MEM_LAT cycles after mem_req_o

Behaviour:
- Reset (rstn low, asynchronous): clear credit counter, latency pipeline valids and FIFO pointers/count.
  - Outputs during reset: fetch_data_valid=0, fetch_data_err=0, fetch_data=0, mem_req_o=0.
  - fetch_addr_ready is combinational; it is 1 in the first cycle after rstn deasserts.
- Accept rule: accept = fetch_addr_valid && fetch_addr_ready.
  - fetch_addr_ready = !flush_i && (inflight < NR_OUTSTANDING).
  - inflight counts requests accepted but not yet popped from the FIFO: pipeline entries plus FIFO entries.
- Address check, combinational on the accepted address:
  - err = (fetch_addr[1:0] != 0) || (fetch_addr < BASE_ADDR) || (((fetch_addr - BASE_ADDR) >> 2) >= MEM_WORDS).
  - mem_req_o = accept && !err.
  - mem_addr_o = ((fetch_addr - BASE_ADDR) >> 2) truncated to index width.
- Latency pipeline: MEM_LAT-deep shift register of {valid, err}, entered on accept.
  - A faulting request still walks the pipeline, so response order is preserved.
  - At stage MEM_LAT the entry is written to the FIFO as {data = err ? 0 : mem_rdata_i, err}.
- Timing: request accepted in cycle T is visible at the FIFO head, fetch_data_valid=1, in cycle T+MEM_LAT+1 at the earliest.
- Response FIFO:
  - fetch_data_valid = !empty.
  - Pop on fetch_data_valid && fetch_data_ready.
  - fetch_data and fetch_data_err hold stable while valid && !ready.
  - The credit limit guarantees the FIFO never overflows. Overflow is an assertion failure.
- Throughput: with fetch_data_ready held high, one request accepted and one word returned per cycle with no bubbles.
- Counter updates, simultaneous events: inflight += accept, inflight -= pop, both in the same cycle. No wrap below 0 or above NR_OUTSTANDING.
- Flush (flush_i=1 in cycle F):
  - fetch_addr_ready=0 in cycle F; no accept.
  - At the clock edge: clear all pipeline valids, FIFO pointers/count and inflight.
  - fetch_data_valid is forced to 0 in cycle F. A pop does not occur, even if fetch_data_ready=1.
  - SRAM reads already issued complete, but their data is discarded because the pipeline valid bits are cleared.
  - Accepts resume in cycle F+1.
- Back-to-back flushes: each one clears state; no response escapes between them.

Test Plan:
- Single fetch, MEM_LAT=2: accept 0x8000_0000 at cycle 0 with SRAM word0=0x0000_0013 → mem_req_o=1, mem_addr_o=0 at cycle 0; fetch_data_valid=1, data=0x00000013, err=0 at cycle 3.
- Streaming: 16 sequential addresses from 0x8000_0000 with ready held high → 16 words in order, one per cycle, from cycle 3 to 18; fetch_addr_ready never drops.
- Backpressure: fetch_data_ready=0 and 6 requests offered → exactly 4 accepted and ready low afterwards. Raise ready → 4 words popped in order; ready rises again in the cycle after the first pop.
- Fault: fetch addresses 0x8000_0002, 0x7FFF_FFFC and BASE+4*MEM_WORDS interleaved with valid ones → faulting requests give mem_req_o=0; their responses have err=1, data=0 and stay in order.
- Flush mid-stream: 3 requests in flight and 1 word in the FIFO, flush_i pulsed → fetch_data_valid=0 from cycle F on. A new request at F+1 returns only its own word at F+1+MEM_LAT+1.
- Reset mid-operation: drop rstn asynchronously with a full FIFO → fetch_data_valid=0 immediately; after release ready=1 and no stale words appear.
